uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter SIZE, default 8, data bits per frame (1..16).
REQ-002 Parameter CLKS_PER_BIT, default 1, TXC cycles per serial bit (>=1).
REQ-003 TXC  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 TXDATA  input  SIZE  parallel word to transmit, sampled only at request acceptance.
REQ-006 TX_RQ  input  1  transmit request, level-sensitive.
REQ-007 TX_BUSY  output  1  high while a frame is in progress.
REQ-008 TXD  output  1  serial line, idle high.

Function
REQ-009 States SHALL be IDLE, START, DATA, PARITY (only with TX_PARITY_EN), STOP.
REQ-010 IDLE: TXD=1, TX_BUSY=0; request accepted on the edge where TX_RQ=1 and state is IDLE.
REQ-011 At acceptance, TXDATA SHALL be latched into a shift register; later TXDATA changes do not affect the frame.
REQ-012 Start bit (TXD=0) SHALL begin the cycle after acceptance; TX_BUSY rises in the same cycle.
REQ-013 DATA SHALL send SIZE bits LSB first, each held exactly CLKS_PER_BIT cycles.
REQ-014 STOP SHALL drive TXD=1 for CLKS_PER_BIT cycles; TX_BUSY stays high through the last stop cycle.
REQ-015 Frame length: (SIZE+2) bit times, plus one with parity; 10 TXC cycles at defaults.
REQ-016 TX_RQ while TX_BUSY=1 SHALL be ignored; no queuing.
REQ-017 TX_RQ high at the end of STOP SHALL go to IDLE for one cycle, accept there, and start the next start bit the following cycle.
REQ-018 TXD and TX_BUSY SHALL be registered outputs; no combinational path from inputs.
REQ-019 Bit counter width $clog2(SIZE+1); baud counter width $clog2(CLKS_PER_BIT+1); no overflow at any legal parameter value.

Reset
REQ-020 RST=1 at a rising edge SHALL force IDLE, TXD=1, TX_BUSY=0, clear shift register and counters.
REQ-021 Reset mid-frame SHALL abort the frame; the line is high from the next cycle; no partial completion.
REQ-022 RST has priority over TX_RQ in the same cycle.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: PARITY state after DATA sends even parity (XOR of latched data bits) for one bit time.
REQ-024 Macro undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Structure
REQ-025 Package uart_tx_pkg SHALL hold the state enum typedef and the TXD idle/start/stop level constants.
REQ-026 Sub-module uart_tx_baud SHALL generate a one-cycle bit-tick every CLKS_PER_BIT cycles, restarted at acceptance.

Verification
REQ-027 Defaults, TXDATA=8'hAA, TX_RQ high for 2 cycles -> TXD sequence 0,0,1,0,1,0,1,0,1,1 over 10 cycles; TX_BUSY high exactly 10 cycles.
REQ-028 TXDATA=8'hCC requested 3 cycles into the 8'hAA frame -> ignored; TXD carries 8'hAA only, then idles high.
REQ-029 TX_RQ held high with TXDATA=8'h55 -> back-to-back frames separated by exactly one idle cycle, each 0,1,0,1,0,1,0,1,0,1.
REQ-030 RST asserted at cycle 5 of the 8'hAA frame -> next cycle TXD=1, TX_BUSY=0; a new request afterward sends a full frame.
REQ-031 CLKS_PER_BIT=4, TXDATA=8'h01 -> each bit held 4 cycles; TX_BUSY high 40 cycles.
REQ-032 UART_TX_PARITY_EN, TXDATA=8'h07 -> parity bit 1 before stop; frame 11 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the uart_tx transmitter.
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_tx_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = S_PARITY,
`endif
        ST_STOP   = S_STOP
    } tx_state_e;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;
    localparam logic TXD_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side request bundle and serial output of the uart_tx block.
// The master drives the word and request; the slave returns busy and line.
interface uart_tx_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] TXDATA;
    logic            TX_RQ;
    logic            TX_BUSY;
    logic            TXD;

    modport master (
        output TXDATA,
        output TX_RQ,
        input  TX_BUSY,
        input  TXD
    );

    modport slave (
        input  TXDATA,
        input  TX_RQ,
        output TX_BUSY,
        output TXD
    );
endinterface

// File: rtl/uart_tx_baud.sv
// Bit-time generator: one-cycle tick on the last cycle of every bit period.
// Restarting aligns the period with the first cycle of a new start bit.
module uart_tx_baud #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, SIZE data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int SIZE         = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic      TXC,
    input  logic      RST,
    uart_tx_if.slave  tx
);

    localparam int BW = $clog2(SIZE + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(SIZE);

    tx_state_e       r_state;
    logic [SIZE-1:0] r_shift;
    logic [BW-1:0]   r_bitcnt;
    logic            r_txd;
    logic            r_busy;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
`endif

    logic w_accept;
    logic w_tick;

    assign w_accept   = (r_state == ST_IDLE) && tx.TX_RQ;
    assign tx.TXD     = r_txd;
    assign tx.TX_BUSY = r_busy;

    uart_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk    (TXC),
        .i_rst    (RST),
        .i_restart(w_accept),
        .o_tick   (w_tick)
    );

    always_ff @(posedge TXC) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_txd    <= TXD_IDLE;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (tx.TX_RQ) begin
                        r_state  <= ST_START;
                        r_shift  <= tx.TXDATA;
                        r_bitcnt <= '0;
                        r_txd    <= TXD_START;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_par    <= ^tx.TXDATA;
`endif
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state  <= ST_DATA;
                        r_txd    <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= BW'(1);
                    end
                end
                // r_bitcnt counts data bits already put on the line
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bitcnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_txd   <= r_par;
`else
                            r_state <= ST_STOP;
                            r_txd   <= TXD_STOP;
`endif
                        end else begin
                            r_txd    <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_txd   <= TXD_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_txd   <= TXD_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= TXD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model checked every cycle, plus literal frames.
// Two instances run side by side: one bit per clock and four clocks per bit.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [15:0] PAT01 = 16'b01000000011;
`else
    localparam int NB = 10;
    localparam logic [15:0] PAT01 = 16'b0100000001;
`endif

    logic clk;
    logic rst;

    uart_tx_if #(.SIZE(8)) f1 ();
    uart_tx_if #(.SIZE(8)) f4 ();

    uart_tx #(.SIZE(8), .CLKS_PER_BIT(1)) dut1 (
        .TXC(clk),
        .RST(rst),
        .tx (f1.slave)
    );

    uart_tx #(.SIZE(8), .CLKS_PER_BIT(4)) dut4 (
        .TXC(clk),
        .RST(rst),
        .tx (f4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    logic l1t [1024];
    logic l1b [1024];
    logic l4t [1024];
    logic l4b [1024];

    bit          act [2];
    int          pos [2];
    logic [15:0] frm [2];

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_assert++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Whole frame as a bit vector, index 0 is the first bit on the line
    function automatic logic [15:0] frame_of(input logic [7:0] d);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int u = 0; u < 2; u++) begin
            automatic int   cpb = (u == 0) ? 1 : 4;
            automatic logic rq  = (u == 0) ? f1.TX_RQ : f4.TX_RQ;
            automatic logic [7:0] d = (u == 0) ? f1.TXDATA : f4.TXDATA;
            if (rst) begin
                act[u] = 1'b0;
                pos[u] = 0;
            end else if (act[u]) begin
                pos[u] = pos[u] + 1;
                if (pos[u] == NB * cpb) act[u] = 1'b0;
            end else if (rq) begin
                act[u] = 1'b1;
                pos[u] = 0;
                frm[u] = frame_of(d);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc < 1024) begin
            l1t[cyc] = f1.TXD;
            l1b[cyc] = f1.TX_BUSY;
            l4t[cyc] = f4.TXD;
            l4b[cyc] = f4.TX_BUSY;
        end
        if (chk_on) begin
            chk("cmp1_txd", 64'(f1.TXD),
                act[0] ? 64'(frm[0][pos[0]]) : 64'd1);
            chk("cmp1_busy", 64'(f1.TX_BUSY), 64'(act[0]));
            chk("cmp4_txd", 64'(f4.TXD),
                act[1] ? 64'(frm[1][pos[1] / 4]) : 64'd1);
            chk("cmp4_busy", 64'(f4.TX_BUSY), 64'(act[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input bit slow, input logic [7:0] d, output int k);
        if (slow) begin
            f4.TXDATA = d;
            f4.TX_RQ  = 1'b1;
        end else begin
            f1.TXDATA = d;
            f1.TX_RQ  = 1'b1;
        end
        tick(1);
        k = cyc;
    endtask

    task automatic chk_seq(input string nm, input bit slow, input int k,
                           input int n, input logic [63:0] et,
                           input logic [63:0] eb);
        logic [63:0] at;
        logic [63:0] ab;
        at = '0;
        ab = '0;
        for (int i = 0; i < n; i++) begin
            at[n-1-i] = slow ? l4t[k+i] : l1t[k+i];
            ab[n-1-i] = slow ? l4b[k+i] : l1b[k+i];
        end
        chk({nm, "_txd"}, at, et);
        chk({nm, "_busy"}, ab, eb);
    endtask

    initial begin
        int k0;
        int k1;
        logic [63:0] e48;
        rst       = 1'b1;
        f1.TX_RQ  = 1'b0;
        f1.TXDATA = '0;
        f4.TX_RQ  = 1'b0;
        f4.TXDATA = '0;
        #1;
        tick(1);
        chk_on = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_txd1", 64'(f1.TXD), 64'd1);
        chk("rst_busy1", 64'(f1.TX_BUSY), 64'd0);
        chk("rst_txd4", 64'(f4.TXD), 64'd1);
        chk("rst_busy4", 64'(f4.TX_BUSY), 64'd0);

        // 0xAA with request held for two cycles
        go(1'b0, 8'hAA, k0);
        tick(1);
        f1.TX_RQ = 1'b0;
        tick(14);
`ifdef UART_TX_PARITY_EN
        chk_seq("aa", 1'b0, k0, 12, 64'b001010101011, 64'b111111111110);
`else
        chk_seq("aa", 1'b0, k0, 12, 64'b001010101111, 64'b111111111100);
`endif

        // 0xCC request while busy must be dropped
        go(1'b0, 8'hAA, k0);
        f1.TX_RQ = 1'b0;
        tick(2);
        f1.TXDATA = 8'hCC;
        f1.TX_RQ  = 1'b1;
        tick(1);
        f1.TX_RQ  = 1'b0;
        tick(14);
`ifdef UART_TX_PARITY_EN
        chk_seq("ign", 1'b0, k0, 14, 64'b00101010101111,
                64'b11111111111000);
`else
        chk_seq("ign", 1'b0, k0, 14, 64'b00101010111111,
                64'b11111111110000);
`endif

        // 0x55 with request held: back-to-back frames, one idle cycle apart
        go(1'b0, 8'h55, k0);
        tick(12);
        f1.TX_RQ = 1'b0;
        tick(16);
`ifdef UART_TX_PARITY_EN
        chk_seq("b2b", 1'b0, k0, 25,
                64'b0101010100110101010100111,
                64'b1111111111101111111111100);
`else
        chk_seq("b2b", 1'b0, k0, 23,
                64'b01010101011010101010111,
                64'b11111111110111111111100);
`endif

        // Reset in the middle of a frame
        go(1'b0, 8'hAA, k0);
        f1.TX_RQ = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        chk_seq("abort", 1'b0, k0, 7, 64'b0010111, 64'b1111100);
        go(1'b0, 8'hAA, k1);
        f1.TX_RQ = 1'b0;
        tick(14);
`ifdef UART_TX_PARITY_EN
        chk_seq("after", 1'b0, k1, 12, 64'b001010101011, 64'b111111111110);
`else
        chk_seq("after", 1'b0, k1, 12, 64'b001010101111, 64'b111111111100);
`endif

        // Four clocks per bit, 0x01
        go(1'b1, 8'h01, k0);
        f4.TX_RQ = 1'b0;
        tick(50);
        e48 = '0;
        for (int i = 0; i < 48; i++) begin
            e48[47-i] = (i / 4 < NB) ? PAT01[NB-1-(i/4)] : 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        chk_seq("slow", 1'b1, k0, 48, e48, 64'hFFFF_FFFF_FFF0);
`else
        chk_seq("slow", 1'b1, k0, 48, e48, 64'hFFFF_FFFF_FF00);
`endif

        // 0x07: three ones, parity bit is 1 when enabled
        go(1'b0, 8'h07, k0);
        f1.TX_RQ = 1'b0;
        tick(14);
`ifdef UART_TX_PARITY_EN
        chk_seq("p07", 1'b0, k0, 12, 64'b011100000111, 64'b111111111110);
`else
        chk_seq("p07", 1'b0, k0, 12, 64'b011100000111, 64'b111111111100);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
